// File: rtl/game_pkg.sv
// Shared types, constants and board tile accessors for the 2048 game blocks.
package game_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef logic [3:0] tile_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PROC = 2'b01,
    ST_DONE = 2'b10
  } mover_state_t;

  localparam tile_t MAX_EXP = 4'd15;
  localparam int    BOARD_W = 64;

  function automatic tile_t get_tile(input logic [BOARD_W-1:0] b,
                                     input logic [1:0] r,
                                     input logic [1:0] c);
    return b[{r, c, 2'b00} +: 4];
  endfunction

  function automatic logic [BOARD_W-1:0] set_tile(input logic [BOARD_W-1:0] b,
                                                  input logic [1:0] r,
                                                  input logic [1:0] c,
                                                  input tile_t t);
    logic [BOARD_W-1:0] nb;
    nb = b;
    nb[{r, c, 2'b00} +: 4] = t;
    return nb;
  endfunction

endpackage

// File: rtl/merge_line.sv
// Combinational slide-and-merge of one 4-tile line given in destination order.
module merge_line
  import game_pkg::*;
(
  input  tile_t       t0_i,
  input  tile_t       t1_i,
  input  tile_t       t2_i,
  input  tile_t       t3_i,
  output tile_t       q0_o,
  output tile_t       q1_o,
  output tile_t       q2_o,
  output tile_t       q3_o,
  output logic [16:0] score_o
);

  tile_t       in_s  [0:3];
  tile_t       cmp_s [0:4];
  tile_t       res_s [0:3];
  logic [2:0]  cnt_s;
  logic [1:0]  wr_s;
  logic        skip_s;
  logic [16:0] score_s;

  assign in_s[0] = t0_i;
  assign in_s[1] = t1_i;
  assign in_s[2] = t2_i;
  assign in_s[3] = t3_i;

  // Compress zeros, then merge front-to-back; cmp_s[4] is a zero sentinel.
  always_comb begin
    cmp_s   = '{default: 4'd0};
    res_s   = '{default: 4'd0};
    cnt_s   = 3'd0;
    wr_s    = 2'd0;
    skip_s  = 1'b0;
    score_s = 17'd0;
    for (int i = 0; i < 4; i++) begin
      if (in_s[i] != 4'd0) begin
        cmp_s[cnt_s] = in_s[i];
        cnt_s        = cnt_s + 3'd1;
      end else begin
        cnt_s = cnt_s;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (skip_s) begin
        skip_s = 1'b0;
      end else if (cmp_s[i] != 4'd0) begin
        if ((cmp_s[i] == cmp_s[i+1]) && (cmp_s[i] != MAX_EXP)) begin
          res_s[wr_s] = cmp_s[i] + 4'd1;
          score_s     = score_s + (17'd1 << (cmp_s[i] + 4'd1));
          skip_s      = 1'b1;
        end else begin
          res_s[wr_s] = cmp_s[i];
        end
        wr_s = wr_s + 2'd1;
      end else begin
        skip_s = 1'b0;
      end
    end
  end

  assign q0_o    = res_s[0];
  assign q1_o    = res_s[1];
  assign q2_o    = res_s[2];
  assign q3_o    = res_s[3];
  assign score_o = score_s;

endmodule

// File: rtl/board_mover.sv
// Sequential 4x4 2048 move engine: one line merged per clock, results registered on DONE entry.
module board_mover
  import game_pkg::*;
#(
  parameter int WIN_EXP = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  dir,
  input  logic [63:0] board_in,
  output logic        busy,
  output logic        done,
  output logic [63:0] board_out,
  output logic        moved,
  output logic [18:0] score_delta,
  output logic [3:0]  max_tile,
  output logic        won
);

  mover_state_t state_q, state_d;
  logic [1:0]   idx_q, idx_d;
  logic [63:0]  work_q, work_d;
  logic [63:0]  orig_q, orig_d;
  dir_t         dir_q, dir_d;
  logic [18:0]  acc_q, acc_d;
  logic         load_out_s;

  logic [63:0]  board_out_q;
  logic         moved_q;
  logic [18:0]  score_q;
  logic [3:0]   max_q;
  logic         won_q;

  logic [3:0]   pos_s  [0:3];
  tile_t        line_s [0:3];
  tile_t        res_s  [0:3];
  logic [16:0]  line_score_s;
  logic [63:0]  merged_s;
  logic [3:0]   max_s;
  logic         won_s;

  // Position p of line idx as {r,c}, counted from the destination edge outward.
  function automatic logic [3:0] line_pos(input dir_t d, input logic [1:0] idx,
                                          input logic [1:0] p);
    case (d)
      DIR_LEFT:  return {idx, p};
      DIR_RIGHT: return {idx, 2'd3 - p};
      DIR_UP:    return {p, idx};
      DIR_DOWN:  return {2'd3 - p, idx};
      default:   return {idx, p};
    endcase
  endfunction

  // Gather the active line out of the working board.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      pos_s[p]  = line_pos(dir_q, idx_q, 2'(p));
      line_s[p] = get_tile(work_q, pos_s[p][3:2], pos_s[p][1:0]);
    end
  end

  merge_line u_merge (
    .t0_i    (line_s[0]),
    .t1_i    (line_s[1]),
    .t2_i    (line_s[2]),
    .t3_i    (line_s[3]),
    .q0_o    (res_s[0]),
    .q1_o    (res_s[1]),
    .q2_o    (res_s[2]),
    .q3_o    (res_s[3]),
    .score_o (line_score_s)
  );

  // Scatter the merged line back into a copy of the working board.
  always_comb begin
    merged_s = work_q;
    for (int p = 0; p < 4; p++) begin
      merged_s = set_tile(merged_s, pos_s[p][3:2], pos_s[p][1:0], res_s[p]);
    end
  end

  // Next-state logic; load_out_s marks the edge that enters DONE.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    work_d     = work_q;
    orig_d     = orig_q;
    dir_d      = dir_q;
    acc_d      = acc_q;
    load_out_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PROC;
          work_d  = board_in;
          orig_d  = board_in;
          dir_d   = dir_t'(dir);
          idx_d   = 2'd0;
          acc_d   = 19'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PROC: begin
        work_d = merged_s;
        acc_d  = acc_q + {2'b00, line_score_s};
        idx_d  = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d    = ST_DONE;
          load_out_s = 1'b1;
        end else begin
          state_d = ST_PROC;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Largest exponent of the board about to be published.
  always_comb begin
    max_s = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (work_d[i*4 +: 4] > max_s) begin
        max_s = work_d[i*4 +: 4];
      end else begin
        max_s = max_s;
      end
    end
  end

  assign won_s = (int'(max_s) >= WIN_EXP);

  // FSM, line counter and working registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      work_q  <= 64'd0;
      orig_q  <= 64'd0;
      dir_q   <= DIR_UP;
      acc_q   <= 19'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
      orig_q  <= orig_d;
      dir_q   <= dir_d;
      acc_q   <= acc_d;
    end
  end

  // Result registers, updated only on DONE entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      board_out_q <= 64'd0;
      moved_q     <= 1'b0;
      score_q     <= 19'd0;
      max_q       <= 4'd0;
      won_q       <= 1'b0;
    end else if (load_out_s) begin
      board_out_q <= work_d;
      moved_q     <= (work_d != orig_q);
      score_q     <= acc_d;
      max_q       <= max_s;
      won_q       <= won_s;
    end else begin
      board_out_q <= board_out_q;
      moved_q     <= moved_q;
      score_q     <= score_q;
      max_q       <= max_q;
      won_q       <= won_q;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign board_out   = board_out_q;
  assign moved       = moved_q;
  assign score_delta = score_q;
  assign max_tile    = max_q;
  assign won         = won_q;

endmodule

// File: tb/tb_board_mover.sv
// Vector table plus scoreboard queue of expected move results for board_mover.
module tb_board_mover;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  dir;
  logic [63:0] board_in;
  logic        busy;
  logic        done;
  logic [63:0] board_out;
  logic        moved;
  logic [18:0] score_delta;
  logic [3:0]  max_tile;
  logic        won;

  typedef struct {
    logic [63:0] b;
    logic [1:0]  d;
    logic [63:0] eb;
    logic [18:0] es;
    logic        em;
    logic [3:0]  emx;
    logic        ew;
  } vec_t;

  vec_t vecs [0:9];
  vec_t exp_q [$];
  int   errors;
  int   checks;
  int   ndone_rst;

  board_mover #(.WIN_EXP(11)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dir         (dir),
    .board_in    (board_in),
    .busy        (busy),
    .done        (done),
    .board_out   (board_out),
    .moved       (moved),
    .score_delta (score_delta),
    .max_tile    (max_tile),
    .won         (won)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one move; optionally raise a second start at negedge ign_k after E0.
  task automatic run_move(input vec_t v, input int ign_k);
    vec_t e;
    int   first_k;
    int   ndone;
    first_k = -1;
    ndone   = 0;
    @(negedge clk);
    board_in = v.b;
    dir      = v.d;
    start    = 1'b1;
    exp_q.push_back(v);
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start    = 1'b0;
        board_in = 64'hFFFF_FFFF_FFFF_FFFF;
        dir      = ~v.d;
        check("busy_rise", busy, 64'd1);
      end
      if (k == ign_k) begin
        start    = 1'b1;
        board_in = 64'h1111_1111_1111_1111;
        dir      = 2'b10;
      end else if (k == ign_k + 1) begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        if (first_k < 0) begin
          first_k = k;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done with empty scoreboard expected none");
          end else begin
            e = exp_q.pop_front();
            check("latency", 64'(k), 64'd4);
            check("board_out", board_out, e.eb);
            check("score_delta", {45'd0, score_delta}, {45'd0, e.es});
            check("moved", {63'd0, moved}, {63'd0, e.em});
            check("max_tile", {60'd0, max_tile}, {60'd0, e.emx});
            check("won", {63'd0, won}, {63'd0, e.ew});
          end
        end
      end
      if (k == 5) check("busy_fall", busy, 64'd0);
    end
    check("done_count", 64'(ndone), 64'd1);
    if (first_k < 0 && exp_q.size() > 0) e = exp_q.pop_front();
    check("hold_board", board_out, v.eb);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dir      = 2'b00;
    board_in = 64'd0;

    //          board                    dir    expected board          delta      mv    max   won
    vecs[0] = '{64'h0000_0000_0000_0011, 2'b10, 64'h0000_0000_0000_0002, 19'd4,     1'b1, 4'd2,  1'b0};
    vecs[1] = '{64'h0000_0000_0000_1111, 2'b10, 64'h0000_0000_0000_0022, 19'd8,     1'b1, 4'd2,  1'b0};
    vecs[2] = '{64'h0000_0000_0000_1111, 2'b11, 64'h0000_0000_0000_2200, 19'd8,     1'b1, 4'd2,  1'b0};
    vecs[3] = '{64'h0000_0000_0000_0112, 2'b11, 64'h0000_0000_0000_2200, 19'd4,     1'b1, 4'd2,  1'b0};
    vecs[4] = '{64'h0004_0003_0002_0001, 2'b00, 64'h0004_0003_0002_0001, 19'd0,     1'b0, 4'd4,  1'b0};
    vecs[5] = '{64'h0000_0000_000F_000F, 2'b00, 64'h0000_0000_000F_000F, 19'd0,     1'b0, 4'd15, 1'b1};
    vecs[6] = '{64'hA000_A000_0000_0000, 2'b00, 64'h0000_0000_0000_B000, 19'd2048,  1'b1, 4'd11, 1'b1};
    vecs[7] = '{64'h0000_0002_0001_0001, 2'b01, 64'h0002_0002_0000_0000, 19'd4,     1'b1, 4'd2,  1'b0};
    vecs[8] = '{64'h5000_0000_0000_0101, 2'b10, 64'h0005_0000_0000_0002, 19'd4,     1'b1, 4'd5,  1'b0};
    vecs[9] = '{64'h0000_0000_0000_EEFF, 2'b10, 64'h0000_0000_0000_0FFF, 19'd32768, 1'b1, 4'd15, 1'b1};

    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_board", board_out, 64'd0);
    check("rst_score", {45'd0, score_delta}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_move(vecs[i], -1);

    // Second start at E2 must be ignored.
    run_move(vecs[1], 1);

    // Reset in the middle of a move: outputs cleared, no done for the aborted move.
    ndone_rst = 0;
    @(negedge clk);
    board_in = vecs[6].b;
    dir      = vecs[6].d;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_done", {63'd0, done}, 64'd0);
    check("mid_rst_board", board_out, 64'd0);
    check("mid_rst_misc", {40'd0, score_delta, max_tile, moved, won}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) ndone_rst++;
    end
    check("mid_rst_no_done", 64'(ndone_rst), 64'd0);
    check("mid_rst_board_after", board_out, 64'd0);

    run_move(vecs[0], -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
